apb_regfile_completer: RTL and testbench
========================================

Name: apb_regfile_completer

Overview:
APB3/APB4 completer (responder) exposing a bank of 32-bit read/write registers on the team's APB bus. Sits on the slave side of the APB interface, opposite apb_master; its ports map one-to-one onto the interface slave modport signals. Adds programmable wait states and PSLVERR reporting, so the master's PREADY/PSLVERR handling can be exercised.

Parameters:
NUM_REGS, 4, number of 32-bit registers; must be ≥1. Byte addresses are 0x0 to (NUM_REGS-1)*4.
ADDR_W, 32, PADDR width.
WAIT_STATES, 0, number of ACCESS cycles with PREADY low before completion; range 0–15.
RESET_VAL, 32'h0, reset value of every register.

Ports:
PCLK  in  1  bus clock; all state updates on the rising edge
PRESETn  in  1  reset; asynchronous assert, active low
PSEL  in  1  completer select
PENABLE  in  1  access phase marker
PWRITE  in  1  1 = write, 0 = read
PADDR  in  ADDR_W  byte address
PWDATA  in  32  write data
PSTRB  in  4  byte-lane strobes; present only with APB_PSTRB_EN
PRDATA  out  32  read data
PREADY  out  1  transfer completion
PSLVERR  out  1  transfer error, valid only while PREADY=1

Behaviour:
- Clock and reset (already decided): one clock, PCLK; reset PRESETn is asynchronous and active-low.
- While PRESETn=0:
  - state = IDLE, wait counter = 0, err flag = 0
  - all registers = RESET_VAL
  - PREADY = 0, PSLVERR = 0, PRDATA = 0
- Reset asserted mid-transfer aborts the transfer. No register is written.
- States: IDLE, ACCESS.
- IDLE:
  - PSEL=1 and PENABLE=0 is the SETUP cycle.
  - At that edge: latch PADDR, PWRITE and PWDATA; load counter = WAIT_STATES; latch err = (PADDR[1:0]≠0) OR (PADDR ≥ NUM_REGS*4); go to ACCESS.
  - PSEL=1 with PENABLE=1 while in IDLE is a protocol violation: ignore it and stay in IDLE.
- ACCESS:
  - PREADY = (counter==0). This is combinational from registered state.
  - counter≠0: decrement each cycle.
  - counter==0: the transfer completes at this edge; return to IDLE.
  - WAIT_STATES=0 gives a 2-cycle transfer. Each wait state adds one cycle.
- Write commit: at the completing edge, if err=0, the register at index latched_addr[..:2] takes the latched PWDATA.
- Read data:
  - PRDATA = reg[index] when ACCESS, PREADY=1, write=0 and err=0.
  - Otherwise PRDATA = 0.
  - A write completing on the same edge is not visible until the next transfer.
- PSLVERR = err AND PREADY in ACCESS, else 0. An errored read returns PRDATA=0. An errored write changes nothing.
- PSEL deasserted during ACCESS: abort, go to IDLE, no write.
- Back-to-back transfers: a SETUP in the cycle right after completion is accepted. No idle cycle is required.

Optional Feature:
Macro APB_PSTRB_EN.
- Defined: the PSTRB port exists and is latched at SETUP. On write commit, only byte lanes with PSTRB[i]=1 are updated; the other lanes keep their old value. PSTRB=4'b0000 on a write is not an error and updates nothing.
- Undefined: no PSTRB port. Every write updates all 4 bytes.

Decomposition:
- Shared package apb_pkg:
  - state enum (IDLE, ACCESS)
  - DATA_W=32 and STRB_W=4 constants
  - function addr_valid(addr, num_regs)
- Sub-module apb_reg_bank:
  - register array with async reset
  - write port: enable, index, data, strobe
  - combinational read port: index → data
- The completer FSM and wait counter stay in apb_regfile_completer.

Test Plan:
1. WAIT_STATES=0: write 0x0 = 9, then read 0x0 → PREADY high in the first ACCESS cycle of each transfer; PRDATA=0x00000009; PSLVERR=0.
2. Write 0xC = 0x4D616B73 ("Maks"), then read 0xC → 0x4D616B73. Read 0x4 → RESET_VAL, unchanged.
3. WAIT_STATES=3: read 0x8 → PREADY low for 3 ACCESS cycles and high on the 4th; transfer spans 5 cycles. PRDATA stays 0 until PREADY=1.
4. Read 0x10 with NUM_REGS=4, and write 0x6 (misaligned) → PSLVERR=1 with PREADY, PRDATA=0. No register changes; verify by reading back 0x4.
5. Assert PRESETn low during the ACCESS of a write of 0xDEADBEEF to 0x8 → outputs go to 0 immediately. After release, read 0x8 → RESET_VAL.
6. APB_PSTRB_EN: write 0x0 = 0xFFFFFFFF, then write 0x0 = 0x12345678 with PSTRB=4'b0101 → read gives 0xFF34FF78.

Source files
------------

// File: rtl/apb_pkg.sv
// ============================================================================
// Module   : apb_pkg
// Purpose  : Shared types, constants and helpers for the APB register-file
//            completer and its register bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

    // Bus data width and number of byte lanes
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    // Completer transfer state
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_t;

    // True when addr is word aligned and lands inside the register window.
    // The address is taken zero-extended to 64 bits so one helper serves any
    // PADDR width up to 64.
    function automatic logic addr_valid(input logic [63:0] addr, input int unsigned num_regs);
        logic [63:0] w_limit;
        w_limit = 64'(num_regs) << 2;
        return (addr[1:0] == 2'b00) && (addr < w_limit);
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_reg_bank.sv
// ============================================================================
// Module   : apb_reg_bank
// Purpose  : Array of 32-bit registers with asynchronous reset, a single
//            byte-strobed write port and a combinational read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int          NUM_REGS  = 4,
    parameter int          IDX_W     = 2,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [STRB_W-1:0] i_wstrb,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [DATA_W-1:0] o_rdata
);

    localparam logic [IDX_W:0] c_NUM_REGS = (IDX_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_rd_in_range;

    // Register array: reset to RESET_VAL, update only the strobed byte lanes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= RESET_VAL;
            end
        end else if (i_we) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (i_wr_idx == IDX_W'(r)) begin
                    for (int l = 0; l < STRB_W; l++) begin
                        if (i_wstrb[l]) begin
                            r_regs[r][8*l +: 8] <= i_wdata[8*l +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read port: an index beyond the array (non power-of-two sizes) reads 0
    always_comb begin
        w_rd_in_range = ({1'b0, i_rd_idx} < c_NUM_REGS);
        o_rdata       = '0;
        if (w_rd_in_range) begin
            o_rdata = r_regs[i_rd_idx];
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_regfile_completer.sv
// ============================================================================
// Module   : apb_regfile_completer
// Purpose  : APB3/APB4 completer exposing NUM_REGS 32-bit registers with
//            programmable wait states and PSLVERR on misaligned or
//            out-of-range addresses.
// Options  : APB_PSTRB_EN - adds the PSTRB port and byte-lane write masking;
//            without it every write updates all four bytes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_regfile_completer
    import apb_pkg::*;
#(
    parameter int          NUM_REGS    = 4,
    parameter int          ADDR_W      = 32,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] RESET_VAL   = 32'h0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
`ifdef APB_PSTRB_EN
    input  logic [STRB_W-1:0] PSTRB,
`endif
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int         IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_STATES);

    apb_state_t          r_state;
    apb_state_t          w_next_state;
    logic [3:0]          r_count;
    logic [IDX_W-1:0]    r_idx;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_err;
    logic [STRB_W-1:0]   w_wstrb;
    logic                w_setup;
    logic                w_addr_ok;
    logic                w_we;
    logic [DATA_W-1:0]   w_rd_data;

    // A SETUP cycle is only recognised from IDLE; PENABLE high there is a
    // protocol violation and is ignored.
    assign w_setup   = (r_state == IDLE) && PSEL && !PENABLE;
    assign w_addr_ok = addr_valid(64'(PADDR), NUM_REGS);

`ifdef APB_PSTRB_EN
    logic [STRB_W-1:0] r_strb;

    // Byte-lane strobes captured with the rest of the SETUP information
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_strb <= '0;
        end else if (w_setup) begin
            r_strb <= PSTRB;
        end
    end

    assign w_wstrb = r_strb;
`else
    assign w_wstrb = '1;
`endif

    // State register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: dropping PSEL in ACCESS aborts, counter at zero completes
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (!PSEL || (r_count == 4'd0)) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs and write strobe, all decoded from registered state
    always_comb begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        w_we    = 1'b0;
        if ((r_state == ACCESS) && (r_count == 4'd0)) begin
            PREADY  = 1'b1;
            PSLVERR = r_err;
            if (!r_write && !r_err) begin
                PRDATA = w_rd_data;
            end
            w_we = PSEL && r_write && !r_err;
        end
    end

    // Transfer context captured at SETUP; wait counter runs down in ACCESS
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_count <= 4'd0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else if (w_setup) begin
            r_count <= c_WAIT_LOAD;
            r_idx   <= PADDR[IDX_W+1:2];
            r_write <= PWRITE;
            r_wdata <= PWDATA;
            r_err   <= !w_addr_ok;
        end else if ((r_state == ACCESS) && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    apb_reg_bank #(
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W),
        .RESET_VAL (RESET_VAL)
    ) u_reg_bank (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .i_we     (w_we),
        .i_wr_idx (r_idx),
        .i_wdata  (r_wdata),
        .i_wstrb  (w_wstrb),
        .i_rd_idx (r_idx),
        .o_rdata  (w_rd_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_apb_regfile_completer.sv
// ============================================================================
// Module   : tb_apb_regfile_completer
// Purpose  : Self-checking bench for apb_regfile_completer. Instance 0 has no
//            wait states, instance 1 has three.
// Options  : APB_PSTRB_EN - exercises byte-lane strobes when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_regfile_completer;

    localparam int          NR = 4;
    localparam logic [31:0] RV = 32'h1234_00FF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  psel = 2'b00;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
`ifdef APB_PSTRB_EN
    logic [3:0]  pstrb = '0;
`endif
    logic [31:0] prdata [2];
    logic        pready [2];
    logic        pslverr [2];

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mdl [2][NR];

    always #5 clk = ~clk;

    apb_regfile_completer #(.NUM_REGS(NR), .ADDR_W(32), .WAIT_STATES(0), .RESET_VAL(RV)) u_dut0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

    apb_regfile_completer #(.NUM_REGS(NR), .ADDR_W(32), .WAIT_STATES(3), .RESET_VAL(RV)) u_dut1 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: registers as plain arrays, errors from address rules
    function automatic logic model_err(input logic [31:0] addr);
        return (addr % 4 != 0) || (addr >= NR * 4);
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [31:0] addr);
        return model_err(addr) ? 32'h0 : mdl[d][addr / 4];
    endfunction

    function automatic void model_write(input int d, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [3:0] strb);
        logic [3:0] lanes;
        lanes = strb;
`ifndef APB_PSTRB_EN
        lanes = 4'hF;
`endif
        if (!model_err(addr)) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes[b]) mdl[d][addr / 4][8*b +: 8] = wdata[8*b +: 8];
            end
        end
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < NR; r++) mdl[d][r] = RV;
    endfunction

    // One APB transfer starting at posedge+1; leaves the bus idle at posedge+1
    // of the completing edge so a following call is back-to-back.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        output logic [31:0] rdata, output logic err, output int waits);
        bit done;
        psel = 2'b00;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite = wr;
        paddr = addr;
        pwdata = wdata;
`ifdef APB_PSTRB_EN
        pstrb = strb;
`else
        if (strb === 4'hx) $display("strobe unknown");
`endif
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        done = 1'b0;
        rdata = '0;
        err = 1'b0;
        while (!done && waits < 40) begin
            @(negedge clk);
            if (pready[d]) begin
                rdata = prdata[d];
                err = pslverr[d];
                done = 1'b1;
            end else begin
                check("prdata_wait", prdata[d], 32'h0);
                check("pslverr_wait", {31'b0, pslverr[d]}, 32'h0);
                waits++;
            end
            @(posedge clk); #1;
        end
        psel = 2'b00;
        penable = 1'b0;
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL xfer_timeout: actual=no PREADY required=PREADY within 40 cycles");
        end
    endtask

    // Transfer checked against the model
    task automatic mx(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input string name);
        logic [31:0] rd, exp_rd;
        logic        er, exp_er;
        int          w;
        exp_rd = wr ? 32'h0 : model_read(d, addr);
        exp_er = model_err(addr);
        xfer(d, wr, addr, wdata, strb, rd, er, w);
        if (wr) model_write(d, addr, wdata, strb);
        check({name, "_rdata"}, rd, exp_rd);
        check({name, "_err"}, {31'b0, er}, {31'b0, exp_er});
        check({name, "_waits"}, w, (d == 0) ? 0 : 3);
    endtask

    typedef struct {
        int          d;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          w;

        vecs[0]  = '{0, 1'b1, 32'h0,  32'h0000_0009, 4'hF, 32'h0,          1'b0};
        vecs[1]  = '{0, 1'b0, 32'h0,  32'h0,         4'hF, 32'h0000_0009,  1'b0};
        vecs[2]  = '{0, 1'b1, 32'hC,  32'h4D61_6B73, 4'hF, 32'h0,          1'b0};
        vecs[3]  = '{0, 1'b0, 32'hC,  32'h0,         4'hF, 32'h4D61_6B73,  1'b0};
        vecs[4]  = '{0, 1'b0, 32'h4,  32'h0,         4'hF, RV,             1'b0};
        vecs[5]  = '{0, 1'b0, 32'h10, 32'h0,         4'hF, 32'h0,          1'b1};
        vecs[6]  = '{0, 1'b1, 32'h6,  32'hFFFF_FFFF, 4'hF, 32'h0,          1'b1};
        vecs[7]  = '{0, 1'b0, 32'h4,  32'h0,         4'hF, RV,             1'b0};
        vecs[8]  = '{1, 1'b0, 32'h8,  32'h0,         4'hF, RV,             1'b0};
        vecs[9]  = '{1, 1'b1, 32'h8,  32'h0BAD_F00D, 4'hF, 32'h0,          1'b0};
        vecs[10] = '{1, 1'b0, 32'h8,  32'h0,         4'hF, 32'h0BAD_F00D,  1'b0};
        vecs[11] = '{0, 1'b0, 32'h8,  32'h0,         4'hF, RV,             1'b0};

        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pready", {31'b0, pready[0]}, 32'h0);
        check("rst_pslverr", {31'b0, pslverr[0]}, 32'h0);
        check("rst_prdata", prdata[0], 32'h0);
        check("rst_pready1", {31'b0, pready[1]}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            xfer(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er, w);
            if (vecs[i].wr) model_write(vecs[i].d, vecs[i].addr, vecs[i].wdata, vecs[i].strb);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d_waits", i), w, (vecs[i].d == 0) ? 0 : 3);
        end

        // PSEL with PENABLE high while idle must be ignored
        psel = 2'b01; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hAAAA_5555;
`ifdef APB_PSTRB_EN
        pstrb = 4'hF;
`endif
        repeat (2) begin
            @(negedge clk);
            check("viol_pready", {31'b0, pready[0]}, 32'h0);
            @(posedge clk); #1;
        end
        psel = 2'b00; penable = 1'b0;
        @(posedge clk); #1;
        mx(0, 1'b0, 32'h0, 32'h0, 4'hF, "viol_readback");

        // PSEL dropped mid-ACCESS on the wait-state instance aborts the write
        psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h55AA_55AA;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("abort_pready", {31'b0, pready[1]}, 32'h0);
        @(posedge clk); #1;
        psel = 2'b00; penable = 1'b0;
        @(posedge clk); #1;
        mx(1, 1'b0, 32'h4, 32'h0, 4'hF, "abort_readback");

        // Byte-lane strobes
        xfer(0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, rd, er, w);
        model_write(0, 32'h0, 32'hFFFF_FFFF, 4'hF);
        xfer(0, 1'b1, 32'h0, 32'h1234_5678, 4'b0101, rd, er, w);
        model_write(0, 32'h0, 32'h1234_5678, 4'b0101);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, er, w);
`ifdef APB_PSTRB_EN
        check("strb_rdata", rd, 32'hFF34_FF78);
`else
        check("nostrb_rdata", rd, 32'h1234_5678);
`endif
        mx(0, 1'b1, 32'h4, 32'hCAFE_0000, 4'b0000, "strb_zero_wr");
        mx(0, 1'b0, 32'h4, 32'h0, 4'hF, "strb_zero_rd");

        // Reset asserted in the completing ACCESS cycle of a write
        psel = 2'b01; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'hDEAD_BEEF;
`ifdef APB_PSTRB_EN
        pstrb = 4'hF;
`endif
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("midrst_pready_before", {31'b0, pready[0]}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_pready", {31'b0, pready[0]}, 32'h0);
        check("midrst_pslverr", {31'b0, pslverr[0]}, 32'h0);
        check("midrst_prdata", prdata[0], 32'h0);
        @(posedge clk); #1;
        psel = 2'b00; penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, w);
        check("midrst_readback", rd, RV);

        // Randomized traffic against the model, with optional idle gaps
        for (int i = 0; i < 80; i++) begin
            int          d;
            logic        wr;
            logic [31:0] a;
            d = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a = $urandom_range(0, NR * 4 + 7);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            mx(d, wr, a, $urandom, 4'($urandom_range(0, 15)), $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
